phy_rx_serial: RTL

//  Receive end of the PHY serial link driven by main_tx. Recovers byte alignment from the
//  bit stream using the reserved idle comma, declares link active after a run of commas,

---
 rtl/phy_rx_serial_pkg.sv | 32 +++
 rtl/phy_rx_serial_rx_byte_aligner.sv | 81 ++++++++
 rtl/phy_rx_serial.sv | 95 +++++++++
 3 files changed

// File: rtl/phy_rx_serial_pkg.sv
// Shared types and constants for the serial PHY receive path.
package phy_rx_serial_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned LANE_COUNT  = 4;
  localparam int unsigned LANE_PTR_W  = 2;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam int unsigned COMMA_CNT_W = 4;
  localparam int unsigned STATS_W     = 16;

  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ACTIVE  = 2'd2
  } rx_state_t;

  // Per-edge view of the byte window handed from the aligner to the lane logic
  typedef struct packed {
    logic [BYTE_W-1:0] data;      // current 8-bit window
    logic              strobe;    // byte boundary reached while ACTIVE
    logic              is_comma;  // window equals the comma byte
    logic              lock_done; // this edge completes the sync comma run
  } rx_byte_t;

  // Saturating increment for the statistics counters
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/phy_rx_serial_rx_byte_aligner.sv
// Byte aligner: shift register, bit counter and comma-based sync FSM.
module rx_byte_aligner
  import phy_rx_serial_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int unsigned       SYNC_COUNT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     data_in,
  output rx_byte_t rx_byte_c,
  output logic     active
);

  rx_state_t              state;
  logic [BYTE_W-2:0]      sr;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [COMMA_CNT_W-1:0] comma_cnt;

  logic [BYTE_W-1:0] window;
  logic              window_comma;
  logic              byte_done;
  logic              sync_reached;

  // Window formed by the stored bits plus the bit being sampled this edge
  assign window       = {sr, data_in};
  assign window_comma = (window == COMMA);
  assign byte_done    = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
  assign sync_reached = ((comma_cnt + COMMA_CNT_W'(1)) == COMMA_CNT_W'(SYNC_COUNT));

  assign rx_byte_c.data      = window;
  assign rx_byte_c.strobe    = (state == ST_ACTIVE) && byte_done;
  assign rx_byte_c.is_comma  = window_comma;
  assign rx_byte_c.lock_done = (state == ST_LOCKING) && byte_done && window_comma && sync_reached;

  // Sync FSM: hunt bit-by-bit, confirm a run of aligned commas, then stay locked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      active    <= 1'b0;
    end else begin
      sr <= window[BYTE_W-2:0];
      case (state)
        ST_SEARCH: begin
          if (window_comma) begin
            bit_cnt   <= '0;
            comma_cnt <= COMMA_CNT_W'(1);
            state     <= ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          if (byte_done) begin
            if (window_comma) begin
              comma_cnt <= comma_cnt + COMMA_CNT_W'(1);
              if (sync_reached) begin
                state  <= ST_ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Misaligned byte: restart the hunt from the next edge
              comma_cnt <= '0;
              bit_cnt   <= '0;
              state     <= ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
        default: begin
          state <= ST_SEARCH;
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_serial.sv
// Serial PHY receiver: comma alignment, link sync and 4-lane byte demux.
// Optional statistics counters are built when PHY_RX_STATS_EN is defined.
module phy_rx_serial
  import phy_rx_serial_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int unsigned       SYNC_COUNT = 4
) (
  input  logic               clk_32f,
  input  logic               reset,
  input  logic               data_in,
  output logic [BYTE_W-1:0]  data_out0,
  output logic [BYTE_W-1:0]  data_out1,
  output logic [BYTE_W-1:0]  data_out2,
  output logic [BYTE_W-1:0]  data_out3,
  output logic               valid_out0,
  output logic               valid_out1,
  output logic               valid_out2,
  output logic               valid_out3,
  output logic               active,
  output logic               idle_out
`ifdef PHY_RX_STATS_EN
  ,
  output logic [STATS_W-1:0] rx_data_cnt,
  output logic [STATS_W-1:0] rx_idle_cnt
`endif
);

  rx_byte_t                              rx_byte_c;
  logic [LANE_COUNT-1:0][BYTE_W-1:0]     lane_data;
  logic [LANE_COUNT-1:0]                 lane_valid;
  logic [LANE_PTR_W-1:0]                 lane_ptr;

  rx_byte_aligner #(
    .COMMA      (COMMA),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_aligner (
    .clk       (clk_32f),
    .rst       (reset),
    .data_in   (data_in),
    .rx_byte_c (rx_byte_c),
    .active    (active)
  );

  assign data_out0  = lane_data[0];
  assign data_out1  = lane_data[1];
  assign data_out2  = lane_data[2];
  assign data_out3  = lane_data[3];
  assign valid_out0 = lane_valid[0];
  assign valid_out1 = lane_valid[1];
  assign valid_out2 = lane_valid[2];
  assign valid_out3 = lane_valid[3];

  // Round-robin lane demux; a comma marks idle and realigns to lane 0
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      lane_data  <= '0;
      lane_valid <= '0;
      lane_ptr   <= '0;
      idle_out   <= 1'b0;
    end else begin
      lane_valid <= '0;
      if (rx_byte_c.strobe) begin
        if (rx_byte_c.is_comma) begin
          idle_out <= 1'b1;
          lane_ptr <= '0;
        end else begin
          lane_data[lane_ptr]  <= rx_byte_c.data;
          lane_valid[lane_ptr] <= 1'b1;
          lane_ptr             <= lane_ptr + LANE_PTR_W'(1);
          idle_out             <= 1'b0;
        end
      end else if (rx_byte_c.lock_done) begin
        idle_out <= 1'b1;
      end
    end
  end

`ifdef PHY_RX_STATS_EN
  // Saturating byte counters, counting only bytes completed while ACTIVE
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      rx_data_cnt <= '0;
      rx_idle_cnt <= '0;
    end else if (rx_byte_c.strobe) begin
      if (rx_byte_c.is_comma) begin
        rx_idle_cnt <= sat_inc(rx_idle_cnt);
      end else begin
        rx_data_cnt <= sat_inc(rx_data_cnt);
      end
    end
  end
`endif

endmodule
